// File: rtl/bank_queue_ctrl.sv
// Bank wait-time ROM sequencer: counts customers from door sensors, holds the teller count,
// and publishes the ROM wait time once the address has been stable for a full settle cycle.
module bank_queue_ctrl #(
  parameter int SYNC_STAGES = 2,
  parameter int MAX_PEOPLE  = 7,
  parameter int TELLER_RST  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enter_i,
  input  logic       exit_i,
  input  logic       teller_we,
  input  logic [1:0] teller_num,
  input  logic [7:0] rom_wtime,
  output logic [2:0] rom_pcount,
  output logic [1:0] rom_tcount,
  output logic [7:0] wtime,
  output logic       wtime_vld,
  output logic       busy,
  output logic       full,
  output logic       empty,
  output logic       closed,
  output logic       overflow,
  output logic       underflow
);

  localparam logic [2:0] MAX_P   = 3'(MAX_PEOPLE);
  localparam logic [1:0] TEL_RST = 2'(TELLER_RST);

  typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE} state_t;

  logic [SYNC_STAGES-1:0] ent_sync_q, ent_sync_d;
  logic [SYNC_STAGES-1:0] ext_sync_q, ext_sync_d;
  logic                   ent_prev_q, ent_prev_d;
  logic                   ext_prev_q, ext_prev_d;
  logic                   enter_e, exit_e;

  logic [2:0] pcount_q, pcount_d;
  logic [1:0] tcount_q, tcount_d;
  logic       ovf_q, ovf_d;
  logic       unf_q, unf_d;
  logic [7:0] wtime_q, wtime_d;
  logic       vld_q, vld_d;
  logic       evt;
  logic       capture;

  state_t state_q, state_d;

  // Sensor synchronisers and rising-edge detect
  always_comb begin
    ent_sync_d = {ent_sync_q[SYNC_STAGES-2:0], enter_i};
    ext_sync_d = {ext_sync_q[SYNC_STAGES-2:0], exit_i};
    ent_prev_d = ent_sync_q[SYNC_STAGES-1];
    ext_prev_d = ext_sync_q[SYNC_STAGES-1];
    enter_e    = ent_sync_q[SYNC_STAGES-1] & ~ent_prev_q;
    exit_e     = ext_sync_q[SYNC_STAGES-1] & ~ext_prev_q;
  end

  // Address update; simultaneous enter and exit cancel without flags
  always_comb begin
    pcount_d = pcount_q;
    ovf_d    = 1'b0;
    unf_d    = 1'b0;
    if (enter_e && !exit_e) begin
      if (pcount_q == MAX_P) ovf_d    = 1'b1;
      else                   pcount_d = pcount_q + 3'd1;
    end else if (exit_e && !enter_e) begin
      if (pcount_q == 3'd0)  unf_d    = 1'b1;
      else                   pcount_d = pcount_q - 3'd1;
    end
    tcount_d = teller_we ? teller_num : tcount_q;
    evt      = (pcount_d != pcount_q) || (tcount_d != tcount_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (evt) state_d = SETTLE;
      SETTLE:  state_d = evt ? SETTLE : CAPTURE;
      CAPTURE: state_d = evt ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A change arriving in CAPTURE suppresses the capture so stale data is never published
  always_comb begin
    capture = (state_q == CAPTURE) && !evt;
    wtime_d = capture ? rom_wtime : wtime_q;
    vld_d   = capture;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_sync_q <= '0;
      ext_sync_q <= '0;
      ent_prev_q <= 1'b0;
      ext_prev_q <= 1'b0;
      pcount_q   <= 3'd0;
      tcount_q   <= TEL_RST;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      wtime_q    <= 8'd0;
      vld_q      <= 1'b0;
    end else begin
      ent_sync_q <= ent_sync_d;
      ext_sync_q <= ext_sync_d;
      ent_prev_q <= ent_prev_d;
      ext_prev_q <= ext_prev_d;
      pcount_q   <= pcount_d;
      tcount_q   <= tcount_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      wtime_q    <= wtime_d;
      vld_q      <= vld_d;
    end
  end

  assign rom_pcount = pcount_q;
  assign rom_tcount = tcount_q;
  assign wtime      = wtime_q;
  assign wtime_vld  = vld_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign busy       = (state_q != IDLE);
  assign full       = (pcount_q == MAX_P);
  assign empty      = (pcount_q == 3'd0);
  assign closed     = (tcount_q == 2'd0);

endmodule

// File: tb/tb_bank_queue_ctrl.sv
// Bench for bank_queue_ctrl: directed scenarios plus random sensor/teller traffic,
// every cycle compared against a sample-history reference model.
module tb_bank_queue_ctrl;

  localparam int SYNC = 2;
  localparam int MAXP = 7;
  localparam int TRST = 1;
  localparam int HLEN = SYNC + 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enter_i = 1'b0;
  logic       exit_i = 1'b0;
  logic       teller_we = 1'b0;
  logic [1:0] teller_num = 2'd0;
  logic [7:0] rom_wtime;
  logic [2:0] rom_pcount;
  logic [1:0] rom_tcount;
  logic [7:0] wtime;
  logic       wtime_vld, busy, full, empty, closed, overflow, underflow;

  int total = 0;
  int bad = 0;
  int vld_seen, ovf_seen, unf_seen;

  // reference model state
  bit   eq[$];
  bit   xq[$];
  int   m_cnt, m_tel;
  bit   m_ev1, m_ev2, m_vld, m_ovf, m_unf, m_busy;
  logic [7:0] m_wtime;

  always #5 clk = ~clk;

  bank_queue_ctrl #(.SYNC_STAGES(SYNC), .MAX_PEOPLE(MAXP), .TELLER_RST(TRST)) dut (
    .clk(clk), .rst_n(rst_n), .enter_i(enter_i), .exit_i(exit_i),
    .teller_we(teller_we), .teller_num(teller_num), .rom_wtime(rom_wtime),
    .rom_pcount(rom_pcount), .rom_tcount(rom_tcount), .wtime(wtime),
    .wtime_vld(wtime_vld), .busy(busy), .full(full), .empty(empty),
    .closed(closed), .overflow(overflow), .underflow(underflow)
  );

  function automatic logic [7:0] rom_fn(input logic [2:0] p, input logic [1:0] t);
    if (t == 2'd0) return 8'd0;
    return 8'(3 * int'(p) / int'(t) + ((t > 2'd1) ? 2 : 0));
  endfunction

  assign rom_wtime = rom_fn(rom_pcount, rom_tcount);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    eq.delete();
    xq.delete();
    for (int i = 0; i < HLEN; i++) begin
      eq.push_back(1'b0);
      xq.push_back(1'b0);
    end
    m_cnt = 0; m_tel = TRST; m_wtime = 8'd0;
    m_ev1 = 0; m_ev2 = 0; m_vld = 0; m_ovf = 0; m_unf = 0; m_busy = 0;
  endtask

  // One clock edge: advance model from sampled inputs, then compare everything.
  task automatic step();
    bit ee, xe, ev;
    int oc, ot;
    @(posedge clk);
    eq.push_back(enter_i); void'(eq.pop_front());
    xq.push_back(exit_i);  void'(xq.pop_front());
    ee = eq[HLEN-1-SYNC] && !eq[HLEN-2-SYNC];
    xe = xq[HLEN-1-SYNC] && !xq[HLEN-2-SYNC];
    oc = m_cnt; ot = m_tel;
    m_ovf = 0; m_unf = 0;
    if (ee && !xe) begin
      if (m_cnt == MAXP) m_ovf = 1; else m_cnt++;
    end else if (xe && !ee) begin
      if (m_cnt == 0) m_unf = 1; else m_cnt--;
    end
    if (teller_we) m_tel = int'(teller_num);
    ev = (oc != m_cnt) || (ot != m_tel);
    // published once the address has held for two edges after its last change
    m_vld = m_ev2 && !m_ev1 && !ev;
    if (m_vld) m_wtime = rom_fn(3'(m_cnt), 2'(m_tel));
    if (ev) m_busy = 1; else if (m_vld) m_busy = 0;
    m_ev2 = m_ev1; m_ev1 = ev;
    #1;
    chk("pcount", rom_pcount, m_cnt);
    chk("tcount", rom_tcount, m_tel);
    chk("wtime", wtime, m_wtime);
    chk("vld", wtime_vld, m_vld);
    chk("busy", busy, m_busy);
    chk("full", full, m_cnt == MAXP);
    chk("empty", empty, m_cnt == 0);
    chk("closed", closed, m_tel == 0);
    chk("overflow", overflow, m_ovf);
    chk("underflow", underflow, m_unf);
    vld_seen += int'(wtime_vld);
    ovf_seen += int'(overflow);
    unf_seen += int'(underflow);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic enter_pulse();
    enter_i = 1'b1; run(2);
    enter_i = 1'b0; run(2);
  endtask

  task automatic exit_pulse();
    exit_i = 1'b1; run(2);
    exit_i = 1'b0; run(2);
  endtask

  task automatic set_tellers(input logic [1:0] n);
    teller_we = 1'b1; teller_num = n; step();
    teller_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    do_reset();
    vld_seen = 0; ovf_seen = 0; unf_seen = 0;

    // Scenario 1: single arrival at one teller
    chk("t1_rst_tcount", rom_tcount, 1);
    chk("t1_rst_empty", empty, 1);
    enter_i = 1'b1;
    run(2);
    chk("t1_cnt_before", rom_pcount, 0);
    step();
    chk("t1_cnt_sync1", rom_pcount, 1);
    run(2);
    chk("t1_vld_sync3", wtime_vld, 1);
    chk("t1_wtime", wtime, 3);
    enter_i = 1'b0;
    run(4);
    chk("t1_vld_count", vld_seen, 1);

    // Scenario 2: teller changes
    enter_pulse(); run(6);
    set_tellers(2'd2); run(4);
    chk("t2_tcount", rom_tcount, 2);
    chk("t2_wtime", wtime, 5);
    repeat (5) enter_pulse();
    run(4);
    set_tellers(2'd3); run(4);
    chk("t2_wtime7", wtime, 9);

    // Scenario 3: saturation at MAX_PEOPLE
    do_reset();
    ovf_seen = 0;
    repeat (8) enter_pulse();
    run(6);
    chk("t3_cnt", rom_pcount, 7);
    chk("t3_full", full, 1);
    chk("t3_ovf_count", ovf_seen, 1);
    chk("t3_wtime", wtime, 21);

    // Scenario 4: underflow and cancelling edges
    do_reset();
    vld_seen = 0; unf_seen = 0;
    exit_pulse(); run(6);
    chk("t4_unf_count", unf_seen, 1);
    chk("t4_cnt", rom_pcount, 0);
    enter_i = 1'b1; exit_i = 1'b1; run(3);
    enter_i = 1'b0; exit_i = 1'b0; run(6);
    chk("t4_cnt_both", rom_pcount, 0);
    chk("t4_unf_both", unf_seen, 1);
    chk("t4_no_vld", vld_seen, 0);

    // Scenario 5: back-to-back arrivals restart settling
    vld_seen = 0;
    for (int i = 0; i < 3; i++) begin
      enter_i = 1'b1; step();
      enter_i = 1'b0; step();
    end
    run(8);
    chk("t5_vld_count", vld_seen, 1);
    chk("t5_cnt", rom_pcount, 3);
    chk("t5_wtime", wtime, 9);

    // Scenario 6: async reset in CAPTURE, sensor held through reset, closed branch
    set_tellers(2'd2);
    step();
    chk("t6_busy_pre", busy, 1);
    enter_i = 1'b1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t6_rst_pcount", rom_pcount, 0);
    chk("t6_rst_tcount", rom_tcount, 1);
    chk("t6_rst_wtime", wtime, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_vld", wtime_vld, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run(8);
    enter_i = 1'b0;
    run(2);
    chk("t6_held_once", rom_pcount, 1);
    set_tellers(2'd0); run(4);
    chk("t6_closed", closed, 1);
    chk("t6_wtime0", wtime, 0);

    // Random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(2) == 0) enter_i = ~enter_i;
      if ($urandom_range(3) == 0) exit_i = ~exit_i;
      teller_we = ($urandom_range(7) == 0);
      teller_num = 2'($urandom_range(3));
      step();
    end
    teller_we = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
